// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// sysid word addresses and the transaction-timeout counter width.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int TO_W = 16;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp), compares them with
// elaboration-time constants and publishes pass/fail/timeout status.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd7,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1385930693,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              read_q, read_d;
  logic              addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              first_q, first_d;

  logic              in_req_s;
  logic              accept_s;
  logic              capture_s;
  logic [TO_W-1:0]   cnt_inc_s;

  assign in_req_s  = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
  assign accept_s  = read_q && !avm.avm_waitrequest;
  // A zero-latency slave may return data in the very cycle the request is accepted.
  assign capture_s = avm.avm_readdatavalid && (in_req_s ? accept_s : 1'b1);
  assign cnt_inc_s = cnt_q + TO_W'(1);

  // Next-state and next-output computation for the read sequence
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    cnt_d      = cnt_q;
    first_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || (AUTO_START && first_q)) begin
          state_d   = ST_REQ_ID;
          read_d    = 1'b1;
          addr_d    = SYSID_ADDR_ID;
          busy_d    = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end else begin
          read_d = 1'b0;
        end
      end
      ST_REQ_ID, ST_WAIT_ID, ST_REQ_TS, ST_WAIT_TS: begin
        cnt_d = cnt_inc_s;
        if (capture_s && (addr_q == SYSID_ADDR_ID)) begin
          id_value_d = avm.avm_readdata;
          id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
          state_d    = ST_REQ_TS;
          read_d     = 1'b1;
          addr_d     = SYSID_ADDR_TS;
          cnt_d      = '0;
        end else if (capture_s) begin
          ts_value_d = avm.avm_readdata;
          ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = ST_FINISH;
          read_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (cnt_inc_s == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
          read_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (in_req_s && accept_s) begin
          read_d  = 1'b0;
          state_d = (addr_q == SYSID_ADDR_ID) ? ST_WAIT_ID : ST_WAIT_TS;
        end else begin
          state_d = state_q;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, bus-request, status and capture registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      addr_q     <= SYSID_ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: behavioural sysid slave plus a scoreboard of
// expected check results, compared whenever the checker pulses done.
module tb_sysid_checker;

  localparam logic [31:0] ID_EXP = 32'd7;
  localparam logic [31:0] TS_EXP = 32'd1385930693;
  localparam int          TO_CYC = 16;

  typedef struct {
    int          trig;
    int          lat;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t sb_q[$];

  // slave configuration and state
  int          cfg_stall = 0;
  int          cfg_lat   = 1;
  logic [31:0] cfg_id    = ID_EXP;
  logic [31:0] cfg_ts    = TS_EXP;
  bit          cfg_drop_ts = 1'b0;
  bit          inject    = 1'b0;
  int          stall_left = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_data = 32'd0;
  bit          prev_stalled = 1'b0;
  logic        prev_addr = 1'b0;

  sysid_checker_if avm_if ();

  sysid_checker #(
    .EXPECTED_ID        (ID_EXP),
    .EXPECTED_TIMESTAMP (TS_EXP),
    .TIMEOUT_CYCLES     (TO_CYC),
    .AUTO_START         (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (avm_if),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input int lat, input logic iok, input logic tok, input logic to,
                          input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.trig = cyc; e.lat = lat; e.id_ok = iok; e.ts_ok = tok; e.to = to; e.idv = idv; e.tsv = tsv;
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input int stall, input int lat, input logic [31:0] idw,
                         input logic [31:0] tsw, input bit drop);
    cfg_stall = stall; cfg_lat = lat; cfg_id = idw; cfg_ts = tsw; cfg_drop_ts = drop;
    stall_left = stall;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    check_val("drain", sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_read"},    avm_if.avm_read, 32'd0);
    check_val({tag, "_addr"},    avm_if.avm_address, 32'd0);
    check_val({tag, "_busy"},    busy, 32'd0);
    check_val({tag, "_done"},    done, 32'd0);
    check_val({tag, "_id_ok"},   id_ok, 32'd0);
    check_val({tag, "_ts_ok"},   ts_ok, 32'd0);
    check_val({tag, "_timeout"}, timeout, 32'd0);
    check_val({tag, "_id_val"},  id_value, 32'd0);
    check_val({tag, "_ts_val"},  ts_value, 32'd0);
  endtask

  // Behavioural sysid slave: stall, then return data with latency 0 or 1
  initial begin
    logic [31:0] d;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_readdata      = 32'd0;
    forever begin
      @(negedge clock);
      if (prev_stalled) begin
        check_val("stall_read", avm_if.avm_read, 32'd1);
        check_val("stall_addr", avm_if.avm_address, prev_addr);
      end
      prev_stalled = 1'b0;
      avm_if.avm_readdatavalid = 1'b0;
      avm_if.avm_waitrequest   = 1'b0;
      if (reset) begin
        pend = 1'b0;
        stall_left = cfg_stall;
      end else if (pend) begin
        avm_if.avm_readdatavalid = 1'b1;
        avm_if.avm_readdata      = pend_data;
        pend = 1'b0;
      end else if (inject) begin
        avm_if.avm_readdatavalid = 1'b1;
        avm_if.avm_readdata      = 32'hDEAD_BEEF;
      end
      if (avm_if.avm_read && !reset) begin
        if (stall_left > 0) begin
          avm_if.avm_waitrequest = 1'b1;
          stall_left--;
          prev_stalled = 1'b1;
          prev_addr    = avm_if.avm_address;
        end else begin
          stall_left = cfg_stall;
          if (!(cfg_drop_ts && avm_if.avm_address)) begin
            d = avm_if.avm_address ? cfg_ts : cfg_id;
            if (cfg_lat == 0) begin
              avm_if.avm_readdatavalid = 1'b1;
              avm_if.avm_readdata      = d;
            end else begin
              pend = 1'b1;
              pend_data = d;
            end
          end
        end
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_done", done, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("latency", cyc - e.trig, e.lat);
          check_val("id_ok",   id_ok, e.id_ok);
          check_val("ts_ok",   ts_ok, e.ts_ok);
          check_val("timeout", timeout, e.to);
          check_val("id_value", id_value, e.idv);
          check_val("ts_value", ts_value, e.tsv);
          check_val("busy_at_done", busy, 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rid, rts;
    int s, l;
    reset = 1'b1;
    tick(3);
    check_reset_state("rst");

    // automatic check after reset release
    reset = 1'b0;
    push_exp(5, 1'b1, 1'b1, 1'b0, ID_EXP, TS_EXP);
    wait_drain(40);
    tick(2);

    // wrong ID; extra starts in WAIT_ID and in the FINISH cycle are ignored
    set_cfg(0, 1, 32'd8, TS_EXP, 1'b0);
    start = 1'b1;
    push_exp(5, 1'b0, 1'b1, 1'b0, 32'd8, TS_EXP);
    tick(1); start = 1'b0;
    tick(1); start = 1'b1;
    tick(1); start = 1'b0;
    tick(2); start = 1'b1;
    tick(1); start = 1'b0;
    tick(10);
    wait_drain(40);

    // three-cycle waitrequest stall on each read
    set_cfg(3, 1, ID_EXP, TS_EXP, 1'b0);
    start = 1'b1;
    push_exp(11, 1'b1, 1'b1, 1'b0, ID_EXP, TS_EXP);
    tick(1); start = 1'b0;
    wait_drain(40);
    tick(2);

    // timestamp never returned: abort TO_CYC cycles after the word-1 request
    set_cfg(0, 1, ID_EXP, TS_EXP, 1'b1);
    start = 1'b1;
    push_exp(3 + TO_CYC, 1'b1, 1'b0, 1'b1, ID_EXP, TS_EXP);
    tick(1); start = 1'b0;
    wait_drain(60);
    tick(2);

    // start in WAIT_ID, reset in WAIT_TS, late readdatavalid in IDLE
    set_cfg(0, 1, ID_EXP, TS_EXP, 1'b0);
    start = 1'b1;
    tick(1); start = 1'b0;
    tick(1); start = 1'b1;
    tick(1); start = 1'b0;
    tick(1); reset = 1'b1;
    tick(1);
    check_reset_state("midrst");
    reset = 1'b0;
    inject = 1'b1;
    push_exp(5, 1'b1, 1'b1, 1'b0, ID_EXP, TS_EXP);
    tick(1); inject = 1'b0;
    wait_drain(40);
    tick(2);

    // zero-latency slave
    set_cfg(0, 0, ID_EXP, TS_EXP, 1'b0);
    start = 1'b1;
    push_exp(3, 1'b1, 1'b1, 1'b0, ID_EXP, TS_EXP);
    tick(1); start = 1'b0;
    wait_drain(40);
    tick(2);

    // mixed stall/latency with random or correct words
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(0, 2);
      l = $urandom_range(0, 1);
      rid = (i % 2 == 0) ? $urandom : ID_EXP;
      rts = (i % 2 == 1) ? $urandom : TS_EXP;
      set_cfg(s, l, rid, rts, 1'b0);
      start = 1'b1;
      push_exp(1 + 2 * (s + 1 + l), rid == ID_EXP, rts == TS_EXP, 1'b0, rid, rts);
      tick(1); start = 1'b0;
      wait_drain(40);
      tick(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
